// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: sequences interrupt entry (drain, push return PC and
// flags, fetch handler vector) and RTI return (pop flags and PC, reload
// fetch and the flag register).
// Optional feature macro: FLAG_SAVE_EN. When it is defined, the flag word is
// pushed on entry and popped on RTI. When it is undefined, only the two PC
// halves are saved, and flags_restore stays at zero.
module interrupt_sequencer #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        rti_req,
    input  logic [31:0] pc_in,
    input  logic [2:0]  flags_in,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        flush,
    output logic        mem_push,
    output logic        mem_pop,
    output logic        vec_read,
    output logic [15:0] mem_wdata,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic        flags_restore_valid,
    output logic [2:0]  flags_restore,
    output logic        busy
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DRAIN, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_FLG, S_VEC_READ,
        S_VEC_LOAD, S_POP_FLG, S_POP_PCL, S_POP_PCH, S_RTI_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          w_to_drain;
    logic          w_drain_done;
    logic          r_pending;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_pc_save_lo;
    logic [15:0]   r_pc_lo;
    logic          r_stall, r_flush, r_mem_push, r_mem_pop, r_vec_read;
    logic          r_pc_load, r_frv, r_busy;
    logic [15:0]   r_mem_wdata;
    logic          w_stall, w_flush, w_mem_push, w_mem_pop, w_vec_read;
    logic          w_pc_load, w_frv, w_busy;
    logic [15:0]   w_mem_wdata;
    logic [31:0]   w_pc_value;

    assign w_drain_done = (r_cnt == CW'(DRAIN_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection; RTI takes priority over any interrupt in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_to_drain   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rti_req) begin
`ifdef FLAG_SAVE_EN
                    w_next_state = S_POP_FLG;
`else
                    w_next_state = S_POP_PCL;
`endif
                end else if (r_pending || int_req) begin
                    w_next_state = S_DRAIN;
                    w_to_drain   = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_next_state = S_PUSH_PCH;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            S_PUSH_PCH: w_next_state = S_PUSH_PCL;
`ifdef FLAG_SAVE_EN
            S_PUSH_PCL: w_next_state = S_PUSH_FLG;
`else
            S_PUSH_PCL: w_next_state = S_VEC_READ;
`endif
            S_PUSH_FLG: w_next_state = S_VEC_READ;
            S_VEC_READ: w_next_state = S_VEC_LOAD;
            S_VEC_LOAD: w_next_state = S_IDLE;
            S_POP_FLG:  w_next_state = S_POP_PCL;
            S_POP_PCL:  w_next_state = S_POP_PCH;
            S_POP_PCH:  w_next_state = S_RTI_DONE;
            S_RTI_DONE: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Pending interrupt latch and drain counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_cnt     <= {CW{1'b0}};
        end else begin
            if (w_to_drain) begin
                r_pending <= 1'b0;
            end else if (int_req) begin
                r_pending <= 1'b1;
            end
            if (w_to_drain) begin
                r_cnt <= {CW{1'b0}};
            end else if (r_state == S_DRAIN) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Captured return PC (low half) and popped PC low half / flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_save_lo <= 16'h0000;
            r_pc_lo      <= 16'h0000;
        end else begin
            if ((r_state == S_DRAIN) && w_drain_done) begin
                r_pc_save_lo <= pc_in[15:0];
            end
            if (r_state == S_POP_PCH) begin
                r_pc_lo <= mem_rdata;
            end
        end
    end

`ifdef FLAG_SAVE_EN
    logic [2:0] r_flags;

    // Flag word popped first during RTI; it arrives in the POP_PCL cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 3'b000;
        end else if (r_state == S_POP_PCL) begin
            r_flags <= mem_rdata[2:0];
        end
    end

    assign flags_restore = r_flags;
`else
    assign flags_restore = 3'b000;
`endif

    // Output decode from the next state so the registered strobes line up
    // with the state they belong to. The high PC half is taken straight from
    // pc_in because it is being captured on the same edge.
    always_comb begin
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        w_mem_push  = 1'b0;
        w_mem_pop   = 1'b0;
        w_vec_read  = 1'b0;
        w_pc_load   = 1'b0;
        w_frv       = 1'b0;
        w_busy      = 1'b0;
        w_mem_wdata = 16'h0000;
        if (w_next_state != S_IDLE) begin
            w_stall = 1'b1;
            w_busy  = 1'b1;
        end else begin
            w_stall = 1'b0;
            w_busy  = 1'b0;
        end
        case (w_next_state)
            S_DRAIN:    w_flush = 1'b1;
            S_PUSH_PCH: begin
                w_mem_push  = 1'b1;
                w_mem_wdata = pc_in[31:16];
            end
            S_PUSH_PCL: begin
                w_mem_push  = 1'b1;
                w_mem_wdata = r_pc_save_lo;
            end
            S_PUSH_FLG: begin
                w_mem_push  = 1'b1;
                w_mem_wdata = {13'b0, flags_in};
            end
            S_VEC_READ: w_vec_read = 1'b1;
            S_VEC_LOAD: begin
                w_pc_load = 1'b1;
                w_flush   = 1'b1;
            end
            S_POP_FLG:  w_mem_pop = 1'b1;
            S_POP_PCL:  w_mem_pop = 1'b1;
            S_POP_PCH:  w_mem_pop = 1'b1;
            S_RTI_DONE: begin
                w_pc_load = 1'b1;
`ifdef FLAG_SAVE_EN
                w_frv     = 1'b1;
`else
                w_frv     = 1'b0;
`endif
            end
            default:    w_flush = 1'b0;
        endcase
    end

    // Registered strobes and write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall     <= 1'b0;
            r_flush     <= 1'b0;
            r_mem_push  <= 1'b0;
            r_mem_pop   <= 1'b0;
            r_vec_read  <= 1'b0;
            r_pc_load   <= 1'b0;
            r_frv       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_wdata <= 16'h0000;
        end else begin
            r_stall     <= w_stall;
            r_flush     <= w_flush;
            r_mem_push  <= w_mem_push;
            r_mem_pop   <= w_mem_pop;
            r_vec_read  <= w_vec_read;
            r_pc_load   <= w_pc_load;
            r_frv       <= w_frv;
            r_busy      <= w_busy;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    // New PC: memory data only arrives in the load cycle itself, so it is
    // steered through to pc_value during pc_load and held at zero otherwise.
    always_comb begin
        w_pc_value = 32'h0000_0000;
        if (r_pc_load) begin
            if (r_state == S_RTI_DONE) begin
                w_pc_value = {mem_rdata, r_pc_lo};
            end else begin
                w_pc_value = {16'h0000, mem_rdata};
            end
        end else begin
            w_pc_value = 32'h0000_0000;
        end
    end

    assign stall               = r_stall;
    assign flush               = r_flush;
    assign mem_push            = r_mem_push;
    assign mem_pop             = r_mem_pop;
    assign vec_read            = r_vec_read;
    assign mem_wdata           = r_mem_wdata;
    assign pc_load             = r_pc_load;
    assign pc_value            = w_pc_value;
    assign flags_restore_valid = r_frv;
    assign busy                = r_busy;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: a transaction-level model turns
// each accepted request into timed expected events; a monitor compares them
// against DUT strobes and also emulates the stack/vector memory.
module tb_interrupt_sequencer;

    localparam int DC = 3;
`ifdef FLAG_SAVE_EN
    localparam int FS = 1;
`else
    localparam int FS = 0;
`endif
    localparam int K_PUSH = 0;
    localparam int K_POP  = 1;
    localparam int K_VEC  = 2;
    localparam int K_LOAD = 3;

    logic        clk = 1'b0;
    logic        reset, int_req, rti_req;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic [15:0] mem_rdata;
    logic        stall, flush, mem_push, mem_pop, vec_read, pc_load;
    logic        flags_restore_valid, busy;
    logic [15:0] mem_wdata;
    logic [31:0] pc_value;
    logic [2:0]  flags_restore;

    interrupt_sequencer #(.DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .int_req(int_req), .rti_req(rti_req),
        .pc_in(pc_in), .flags_in(flags_in), .mem_rdata(mem_rdata),
        .stall(stall), .flush(flush), .mem_push(mem_push), .mem_pop(mem_pop),
        .vec_read(vec_read), .mem_wdata(mem_wdata), .pc_load(pc_load),
        .pc_value(pc_value), .flags_restore_valid(flags_restore_valid),
        .flags_restore(flags_restore), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] data;
        logic [2:0]  flg;
        bit          rti;
    } ev_t;
    typedef struct {
        logic [31:0] pc;
        logic [2:0]  flg;
    } ctx_t;

    ev_t         expq[$];
    ctx_t        ctxq[$];
    logic [15:0] mstk[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          sb_en = 1'b0;
    int          free_at = 0;
    logic [15:0] vec_val = 16'h0000;
    logic [15:0] mem_nxt = 16'h0000;
    logic [31:0] last_load_pc = 32'h0;
    logic [2:0]  last_load_flg = 3'b000;
    int          last_load_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push_ev(input int c, input int k, input logic [31:0] d,
                           input logic [2:0] f, input bit r);
        ev_t e;
        e.cyc = c; e.kind = k; e.data = d; e.flg = f; e.rti = r;
        expq.push_back(e);
    endtask

    // Interrupt accepted in IDLE cycle a: drain DC cycles, push, vector fetch.
    task automatic exp_entry(input int a);
        ctx_t c;
        c.pc = pc_in; c.flg = flags_in;
        push_ev(a + DC + 1, K_PUSH, {16'h0000, pc_in[31:16]}, 3'b000, 1'b0);
        push_ev(a + DC + 2, K_PUSH, {16'h0000, pc_in[15:0]}, 3'b000, 1'b0);
        if (FS != 0) push_ev(a + DC + 3, K_PUSH, {29'h0, flags_in}, 3'b000, 1'b0);
        push_ev(a + DC + 3 + FS, K_VEC, 32'h0, 3'b000, 1'b0);
        push_ev(a + DC + 4 + FS, K_LOAD, {16'h0000, vec_val}, 3'b000, 1'b0);
        ctxq.push_back(c);
        free_at = a + DC + 5 + FS;
    endtask

    // RTI accepted in IDLE cycle a: 2+FS pops, then restore most recent context.
    task automatic exp_rti(input int a);
        ctx_t c;
        c = ctxq.pop_back();
        for (int i = 1; i <= 2 + FS; i++) push_ev(a + i, K_POP, 32'h0, 3'b000, 1'b0);
        push_ev(a + 3 + FS, K_LOAD, c.pc, (FS != 0) ? c.flg : 3'b000, 1'b1);
        free_at = a + 4 + FS;
    endtask

    // Memory responder (stack + vector) and scoreboard monitor.
    initial begin
        forever begin
            logic [15:0] nxt;
            int n_strb, kind;
            ev_t e;
            @(negedge clk);
            nxt = 16'($urandom);
            if (mem_push) mstk.push_back(mem_wdata);
            if (mem_pop && mstk.size() > 0) nxt = mstk.pop_back();
            if (vec_read) nxt = vec_val;
            mem_nxt = nxt;
            if (sb_en) begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    chk("missed_event_cycle", cyc, expq[0].cyc);
                    void'(expq.pop_front());
                end
                chk("busy_vs_stall", busy, stall);
                n_strb = int'(mem_push) + int'(mem_pop) + int'(vec_read) + int'(pc_load);
                if (n_strb != 0) begin
                    chk("one_strobe", n_strb, 1);
                    kind = pc_load ? K_LOAD : (vec_read ? K_VEC : (mem_pop ? K_POP : K_PUSH));
                    chk("event_expected", expq.size() != 0, 1'b1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("event_kind", kind, e.kind);
                        if (e.kind == K_PUSH) chk("push_data", mem_wdata, e.data[15:0]);
                        if (e.kind == K_LOAD) begin
                            chk("pc_value", pc_value, e.data);
                            chk("flags_restore_valid", flags_restore_valid, e.rti ? FS : 0);
                            chk("load_flush", flush, !e.rti);
                            if (e.rti) chk("flags_restore", flags_restore, e.flg);
                        end
                    end
                    if (pc_load) begin
                        last_load_pc  = pc_value;
                        last_load_flg = flags_restore;
                        last_load_cyc = cyc;
                    end
                end else begin
                    chk("frv_without_load", flags_restore_valid, 1'b0);
                end
            end
        end
    end

    // Drives mem_rdata one cycle after the strobe that requested it.
    initial begin
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1 mem_rdata = mem_nxt;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        while (cyc < free_at) tick();
    endtask

    task automatic rand_ctx();
        pc_in    = $urandom;
        flags_in = 3'($urandom);
        vec_val  = 16'($urandom);
    endtask

    task automatic do_int();
        wait_free();
        rand_ctx();
        int_req = 1'b1;
        exp_entry(cyc);
        tick();
        int_req = 1'b0;
    endtask

    task automatic do_rti();
        wait_free();
        rti_req = 1'b1;
        exp_rti(cyc);
        tick();
        rti_req = 1'b0;
    endtask

    task automatic do_both();
        wait_free();
        rand_ctx();
        int_req = 1'b1;
        rti_req = 1'b1;
        exp_rti(cyc);
        exp_entry(free_at);
        tick();
        int_req = 1'b0;
        rti_req = 1'b0;
    endtask

    // Second interrupt arrives while the first is still in progress.
    task automatic do_double(input int off, input bit with_rti);
        int r, f;
        wait_free();
        rand_ctx();
        r = cyc;
        int_req = 1'b1;
        exp_entry(r);
        f = free_at;
        tick();
        int_req = 1'b0;
        while (cyc < r + off) tick();
        int_req = 1'b1;
        rti_req = with_rti;
        exp_entry(f);
        tick();
        int_req = 1'b0;
        rti_req = 1'b0;
    endtask

    initial begin
        int r, op, pcnt;
        reset = 1'b1; int_req = 1'b0; rti_req = 1'b0;
        pc_in = 32'h0; flags_in = 3'b000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_strobes", {stall, flush, mem_push, mem_pop, vec_read, pc_load, flags_restore_valid}, 7'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_wdata", mem_wdata, 16'h0000);
        chk("reset_pc_value", pc_value, 32'h0);
        chk("reset_flags_restore", flags_restore, 3'b000);
        tick();
        free_at = cyc;
        sb_en = 1'b1;

        // Known interrupt entry.
        wait_free();
        pc_in = 32'h0001_2345; flags_in = 3'b101; vec_val = 16'h0100;
        r = cyc;
        int_req = 1'b1;
        exp_entry(r);
        tick();
        int_req = 1'b0;
        wait_free();
        chk("tp_entry_pc", last_load_pc, 32'h0000_0100);
        chk("tp_entry_latency", last_load_cyc - r, DC + 4 + FS);

        // Matching RTI.
        r = cyc;
        rti_req = 1'b1;
        exp_rti(r);
        tick();
        rti_req = 1'b0;
        wait_free();
        chk("tp_rti_pc", last_load_pc, 32'h0001_2345);
        chk("tp_rti_flags", last_load_flg, (FS != 0) ? 3'b101 : 3'b000);
        chk("tp_rti_latency", last_load_cyc - r, 3 + FS);

        // Simultaneous requests, then a second interrupt during PUSH_PCH.
        do_int();
        do_both();
        do_double(DC + 1, 1'b0);

        // Randomised mix.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            if ((op == 1 || op == 2) && ctxq.size() == 0) op = 0;
            wait_free();
            repeat ($urandom_range(0, 2)) tick();
            case (op)
                0: do_int();
                1: do_rti();
                2: do_both();
                default: do_double($urandom_range(1, DC + 4 + FS), 1'($urandom));
            endcase
        end
        while (cyc < free_at + 4) tick();
        chk("queue_drained", expq.size(), 0);

        // Reset in the middle of PUSH_PCL.
        sb_en = 1'b0;
        rand_ctx();
        r = cyc;
        int_req = 1'b1;
        tick();
        int_req = 1'b0;
        while (cyc < r + DC + 2) tick();
        @(negedge clk);
        chk("rst_mid_in_pcl", mem_push, 1'b1);
        chk("rst_mid_pcl_data", mem_wdata, pc_in[15:0]);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_strobes", {stall, flush, mem_push, mem_pop, vec_read, pc_load, flags_restore_valid}, 7'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_wdata", mem_wdata, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        pcnt = 0;
        repeat (20) begin
            @(negedge clk);
            pcnt += int'(mem_push);
        end
        chk("rst_mid_no_push", pcnt, 0);
        chk("rst_mid_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
